multdiv_sequencer: RTL and testbench

//   Issue/stall controller between the pipeline X stage and the multdiv unit.

---
 rtl/multdiv_sequencer.sv | 139 +++++++++++++
 tb/tb_multdiv_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// Issue/stall sequencer between pipeline X stage and the multdiv unit: accepts one
// request in IDLE, pulses ctrl for one cycle, waits for a qualified RDY (or times out), writes back once.
module multdiv_sequencer #(
  parameter int MIN_WAIT   = 1,
  parameter int MAX_CYCLES = 40,
  parameter int EXC_REG    = 30,
  parameter int MULT_CODE  = 4,
  parameter int DIV_CODE   = 5
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_mult_i,
  input  logic        start_div_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [4:0]  dest_reg_i,
  output logic        md_ctrl_MULT_o,
  output logic        md_ctrl_DIV_o,
  output logic [31:0] md_operandA_o,
  output logic [31:0] md_operandB_o,
  input  logic [31:0] md_result_i,
  input  logic        md_exception_i,
  input  logic        md_resultRDY_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_reg_o,
  output logic [31:0] wb_data_o
);

  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [4:0]  dest_q, dest_d;
  logic        is_div_q, is_div_d;
  logic        ctrl_mult_q, ctrl_mult_d, ctrl_div_q, ctrl_div_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic accept, rdy_ok, timeout;

  assign accept  = (state_q == S_IDLE) && (start_mult_i || start_div_i);
  // RDY seen too soon after the pulse may belong to the previous operation
  assign rdy_ok  = (cnt_q >= CW'(MIN_WAIT)) && md_resultRDY_i;
  assign timeout = (cnt_q == CW'(MAX_CYCLES - 1));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      dest_q      <= '0;
      is_div_q    <= 1'b0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      dest_q      <= dest_d;
      is_div_q    <= is_div_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
      wb_valid_q  <= wb_valid_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (rdy_ok || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    dest_d      = dest_q;
    is_div_d    = is_div_q;
    ctrl_mult_d = 1'b0;
    ctrl_div_d  = 1'b0;
    wb_valid_d  = 1'b0;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_a_d      = op_a_i;
          op_b_d      = op_b_i;
          dest_d      = dest_reg_i;
          is_div_d    = !start_mult_i;
          ctrl_mult_d = start_mult_i;
          ctrl_div_d  = !start_mult_i;
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (rdy_ok || timeout) begin
          wb_valid_d = 1'b1;
          if (rdy_ok && !md_exception_i) begin
            wb_reg_d  = dest_q;
            wb_data_d = md_result_i;
          end else begin
            wb_reg_d  = 5'(EXC_REG);
            wb_data_d = is_div_q ? 32'(DIV_CODE) : 32'(MULT_CODE);
          end
        end
      end
      default: ;
    endcase
  end

  assign stall_o        = accept || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign md_ctrl_MULT_o = ctrl_mult_q;
  assign md_ctrl_DIV_o  = ctrl_div_q;
  assign md_operandA_o  = op_a_q;
  assign md_operandB_o  = op_b_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_reg_o       = wb_reg_q;
  assign wb_data_o      = wb_data_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: a latency-programmable multdiv stub plus a per-operation
// reference model predicting writeback register, value and cycle of the strobe.
module tb_multdiv_sequencer;
  localparam int MIN_WAIT = 1, MAX_CYCLES = 40, EXC_REG = 30, MULT_CODE = 4, DIV_CODE = 5;

  logic clk = 1'b0;
  logic rst;
  logic start_mult, start_div;
  logic [31:0] op_a, op_b;
  logic [4:0]  dest;
  logic md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_operandA, md_operandB, md_result;
  logic md_exception, md_resultRDY;
  logic stall, wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multdiv_sequencer #(.MIN_WAIT(MIN_WAIT), .MAX_CYCLES(MAX_CYCLES), .EXC_REG(EXC_REG),
                      .MULT_CODE(MULT_CODE), .DIV_CODE(DIV_CODE)) dut (
    .clock_i(clk), .reset_i(rst), .start_mult_i(start_mult), .start_div_i(start_div),
    .op_a_i(op_a), .op_b_i(op_b), .dest_reg_i(dest),
    .md_ctrl_MULT_o(md_ctrl_MULT), .md_ctrl_DIV_o(md_ctrl_DIV),
    .md_operandA_o(md_operandA), .md_operandB_o(md_operandB),
    .md_result_i(md_result), .md_exception_i(md_exception), .md_resultRDY_i(md_resultRDY),
    .stall_o(stall), .wb_valid_o(wb_valid), .wb_reg_o(wb_reg), .wb_data_o(wb_data)
  );

  // Behaviour of the arithmetic unit: {exception, result}
  function automatic logic [32:0] unit_calc(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic signed [31:0] q;
    if (is_mult) begin
      p = $signed(a) * $signed(b);
      return {p != {{32{p[31]}}, p[31:0]}, p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  // Multdiv stub: RDY rises s_lat cycles after it sees the ctrl pulse
  logic        s_busy = 1'b0;
  int          s_cnt = 0;
  int          s_lat = 1;
  logic [32:0] s_out = '0;

  always @(posedge clk) begin
    if (md_ctrl_MULT || md_ctrl_DIV) begin
      s_busy <= 1'b1;
      s_cnt  <= 0;
      s_out  <= unit_calc(md_ctrl_MULT, md_operandA, md_operandB);
    end else if (s_busy && s_cnt < 1000) begin
      s_cnt <= s_cnt + 1;
    end
  end

  assign md_resultRDY = s_busy && (s_cnt >= s_lat);
  assign md_result    = md_resultRDY ? s_out[31:0] : 32'hDEAD_BEEF;
  assign md_exception = md_resultRDY ? s_out[32] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input int lat, input bit hold_div, input bit both);
    logic [32:0] r;
    int k, exp_lat, seen_at, right_p, wrong_p;
    bit timed, exc, ops_ok, stall_ok;
    logic [4:0]  ereg;
    logic [31:0] edata;
    @(negedge clk);
    s_lat = lat;
    start_mult = is_mult;
    start_div = !is_mult || both;
    op_a = a; op_b = b; dest = d;
    #1 chk({tag, ".stall_accept"}, {31'd0, stall}, 32'd1);
    // Model: RDY is honoured once both the mask and the unit latency have elapsed
    r = unit_calc(is_mult, a, b);
    k = (lat > MIN_WAIT) ? lat : MIN_WAIT;
    timed = (k > MAX_CYCLES - 1);
    if (timed) k = MAX_CYCLES - 1;
    exp_lat = k + 3;
    exc = timed || r[32];
    ereg  = exc ? 5'(EXC_REG) : d;
    edata = exc ? (is_mult ? 32'(MULT_CODE) : 32'(DIV_CODE)) : r[31:0];
    @(negedge clk);
    start_mult = 1'b0;
    start_div = hold_div;
    op_a = $urandom; op_b = $urandom; dest = 5'($urandom);
    seen_at = 0; right_p = 0; wrong_p = 0; ops_ok = 1; stall_ok = 1;
    for (int i = 1; i <= 60 && seen_at == 0; i++) begin
      if (i > 1) @(negedge clk);
      if (md_ctrl_MULT) begin if (is_mult) right_p++; else wrong_p++; end
      if (md_ctrl_DIV)  begin if (!is_mult) right_p++; else wrong_p++; end
      if (md_operandA !== a || md_operandB !== b) ops_ok = 0;
      if (wb_valid === 1'b1) begin
        seen_at = i;
        if (stall !== 1'b0) stall_ok = 0;
        start_div = 1'b0;
      end else if (stall !== 1'b1) stall_ok = 0;
    end
    chk({tag, ".latency"}, seen_at, exp_lat);
    chk({tag, ".wb_reg"}, {27'd0, wb_reg}, {27'd0, ereg});
    chk({tag, ".wb_data"}, wb_data, edata);
    chk({tag, ".pulses"}, right_p, 32'd1);
    chk({tag, ".wrong_pulses"}, wrong_p, 32'd0);
    chk({tag, ".operands_stable"}, {31'd0, ops_ok}, 32'd1);
    chk({tag, ".stall_profile"}, {31'd0, stall_ok}, 32'd1);
    @(negedge clk);
    chk({tag, ".wb_valid_once"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, ".stall_after"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a, b;
    bit m;
    rst = 1'b1; start_mult = 1'b0; start_div = 1'b0; op_a = '0; op_b = '0; dest = '0;
    repeat (2) @(negedge clk);
    chk("reset.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset.wb_reg", {27'd0, wb_reg}, 32'd0);
    chk("reset.wb_data", wb_data, 32'd0);
    chk("reset.stall", {31'd0, stall}, 32'd0);
    chk("reset.ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
    chk("reset.operandA", md_operandA, 32'd0);
    rst = 1'b0;

    run_op("mult7x6", 1, 32'd7, 32'd6, 5'd3, 1, 0, 0);
    chk("mult7x6.value", wb_data, 32'd42);
    run_op("div100_7", 0, 32'd100, 32'd7, 5'd9, 12, 0, 0);
    chk("div100_7.value", wb_data, 32'd14);
    run_op("div_by_zero", 0, 32'd5, 32'd0, 5'd4, 6, 0, 0);
    run_op("mult_ovf", 1, 32'h10000, 32'h10000, 5'd7, 2, 0, 0);
    run_op("div_held", 1, 32'd11, 32'd13, 5'd12, 5, 1, 0);
    run_op("both_starts", 1, 32'hFFFF_FFFE, 32'd3, 5'd2, 0, 0, 1);
    run_op("dest_zero", 1, 32'd9, 32'd9, 5'd0, 1, 0, 0);
    run_op("div_timeout", 0, 32'd50, 32'd5, 5'd6, 500, 0, 0);
    run_op("rdy_at_limit", 0, 32'd77, 32'd7, 5'd8, MAX_CYCLES - 1, 0, 0);

    // Reset in the middle of WAIT: nothing must be written back
    @(negedge clk);
    s_lat = 20; start_mult = 1'b1; op_a = 32'd5; op_b = 32'd5; dest = 5'd1;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset.stall", {31'd0, stall}, 32'd0);
    chk("midreset.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("midreset.ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (wb_valid === 1'b1 || stall !== 1'b0) n++;
    end
    chk("midreset.quiet", n, 32'd0);
    run_op("after_reset3x3", 1, 32'd3, 32'd3, 5'd5, 1, 0, 0);
    chk("after_reset3x3.value", wb_data, 32'd9);

    for (int t = 0; t < 20; t++) begin
      m = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 2) == 0) begin a = a & 32'hFFFF; b = b & 32'hFFF; end
      if (!m && $urandom_range(0, 4) == 0) b = 32'd0;
      if (a == 32'h8000_0000) a = 32'd1;
      run_op("random", m, a, b, 5'($urandom), ($urandom_range(0, 9) == 0) ? 80 : int'($urandom_range(0, 8)),
             1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
